int_fu_scheduler: RTL and testbench

//  Round-robin scheduler that shares one 16-bit integer add/sub functional unit among NREQ issue requesters.
//  It grants one request at a time and latches the operands.
//  It models a fixed LAT-cycle execution stage, marks the unit busy meanwhile, and holds the result until writeback accepts it.
//  It sits between scoreboard issue logic and the integer writeback bus.

---
 rtl/int_fu_pkg.sv | 22 ++
 rtl/int_fu_scheduler_if.sv | 34 +++
 rtl/int_addsub.sv | 54 +++++
 rtl/int_fu_scheduler.sv | 166 ++++++++++++++++
 tb/tb_int_fu_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_fu_pkg.sv
// Shared types and constants for the integer add/sub functional-unit scheduler.
package int_fu_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } fu_state_t;

  // Operands captured at grant time.
  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } fu_operands_t;

endpackage

// File: rtl/int_fu_scheduler_if.sv
// Issue-request and writeback bundle between the scoreboard side and the FU scheduler.
interface int_fu_scheduler_if
  import int_fu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 4
);
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_op;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ*TAGW-1:0]   req_dst;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [DATA_W-1:0]      wb_data;
  logic                   wb_cout;
  logic [TAGW-1:0]        wb_dst;
  logic [IDXW-1:0]        wb_src;
  logic                   fu_busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_dst, wb_ready,
    input  req_ready, wb_valid, wb_data, wb_cout, wb_dst, wb_src, fu_busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_dst, wb_ready,
    output req_ready, wb_valid, wb_data, wb_cout, wb_dst, wb_src, fu_busy
  );

endinterface

// File: rtl/int_addsub.sv
// Combinational 16-bit carry-lookahead adder/subtractor; SUB is a + ~b + 1 and
// cout reports the borrow (a < b unsigned) for SUB.
module int_addsub
  import int_fu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W-1:0] data,
  output logic              cout
);

  localparam int unsigned GRP_W = 4;
  localparam int unsigned NGRP  = DATA_W / GRP_W;

  logic [DATA_W:0] sum;

  // Two-level lookahead: 4-bit group generate/propagate, carries resolved per group.
  function automatic logic [DATA_W:0] cla_add(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y,
                                               input logic              cin);
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [DATA_W:0]   c;
    logic [NGRP-1:0]   gg;
    logic [NGRP-1:0]   gp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int unsigned j = 0; j < NGRP; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int unsigned i = 0; i < GRP_W; i++) begin
        gg[j] = g[j*GRP_W+i] | (p[j*GRP_W+i] & gg[j]);
        gp[j] = gp[j] & p[j*GRP_W+i];
      end
    end
    for (int unsigned j = 0; j < NGRP; j++) begin
      c[(j+1)*GRP_W] = gg[j] | (gp[j] & c[j*GRP_W]);
      for (int unsigned i = 1; i < GRP_W; i++) begin
        c[j*GRP_W+i] = g[j*GRP_W+i-1] | (p[j*GRP_W+i-1] & c[j*GRP_W+i-1]);
      end
    end
    return {c[DATA_W], p ^ c[DATA_W-1:0]};
  endfunction

  always_comb begin
    sum  = cla_add(a, (op == OP_SUB) ? ~b : b, op == OP_SUB);
    data = sum[DATA_W-1:0];
    cout = (op == OP_SUB) ? ~sum[DATA_W] : sum[DATA_W];
  end

endmodule

// File: rtl/int_fu_scheduler.sv
// Round-robin scheduler sharing one add/sub unit among NREQ issue requesters,
// with a fixed LAT-cycle execute stage and a held writeback result.
module int_fu_scheduler
  import int_fu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 4,
  parameter int unsigned LAT  = 2
)(
  input logic               clk,
  input logic               rst,
  int_fu_scheduler_if.slave bus
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LAT - 1);

  fu_state_t         state, state_next;
  logic [IDXW-1:0]   ptr, ptr_next;
  logic [CNTW-1:0]   cnt, cnt_next;
  fu_operands_t      opnd_q, opnd_next;
  logic [TAGW-1:0]   dst_q, dst_next;
  logic [IDXW-1:0]   src_q, src_next;

  logic              arb_any;
  logic [IDXW-1:0]   arb_idx;
  logic              grant;
  logic              sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [TAGW-1:0]   sel_dst;

  logic [DATA_W-1:0] alu_data;
  logic              alu_cout;

  logic              wb_valid_q, wb_valid_next;
  logic [DATA_W-1:0] wb_data_q, wb_data_next;
  logic              wb_cout_q, wb_cout_next;
  logic [TAGW-1:0]   wb_dst_q, wb_dst_next;
  logic [IDXW-1:0]   wb_src_q, wb_src_next;
  logic              fu_busy_q, fu_busy_next;

  // Search ptr+1, ptr+2, ... modulo NREQ for the first valid requester.
  always_comb begin : arb
    arb_any = 1'b0;
    arb_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned cand;
      cand = (32'(ptr) + k) % NREQ;
      if (!arb_any && bus.req_valid[IDXW'(cand)]) begin
        arb_any = 1'b1;
        arb_idx = IDXW'(cand);
      end
    end
  end

  always_comb begin : operand_mux
    sel_op  = OP_ADD;
    sel_a   = '0;
    sel_b   = '0;
    sel_dst = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(arb_idx) == i) begin
        sel_op  = bus.req_op[i];
        sel_a   = bus.req_a[i*DATA_W +: DATA_W];
        sel_b   = bus.req_b[i*DATA_W +: DATA_W];
        sel_dst = bus.req_dst[i*TAGW +: TAGW];
      end
    end
  end

  assign grant = (state == ST_IDLE) && arb_any;

  always_comb begin : ready_decode
    bus.req_ready = '0;
    if (grant) bus.req_ready[arb_idx] = 1'b1;
  end

  int_addsub u_addsub (
    .a    (opnd_q.a),
    .b    (opnd_q.b),
    .op   (opnd_q.op),
    .data (alu_data),
    .cout (alu_cout)
  );

  always_comb begin : fsm_next
    state_next   = state;
    ptr_next     = ptr;
    cnt_next     = cnt;
    opnd_next    = opnd_q;
    dst_next     = dst_q;
    src_next     = src_q;
    wb_data_next = wb_data_q;
    wb_cout_next = wb_cout_q;
    wb_dst_next  = wb_dst_q;
    wb_src_next  = wb_src_q;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          ptr_next   = arb_idx;
          cnt_next   = CNT_INIT;
          opnd_next  = '{op: sel_op, a: sel_a, b: sel_b};
          dst_next   = sel_dst;
          src_next   = arb_idx;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNTW'(1);
        end else begin
          wb_data_next = alu_data;
          wb_cout_next = alu_cout;
          wb_dst_next  = dst_q;
          wb_src_next  = src_q;
          state_next   = ST_WB;
        end
      end
      ST_WB: begin
        if (bus.wb_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    wb_valid_next = (state_next == ST_WB);
    fu_busy_next  = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= IDXW'(NREQ - 1);
      cnt        <= '0;
      opnd_q     <= '0;
      dst_q      <= '0;
      src_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_cout_q  <= 1'b0;
      wb_dst_q   <= '0;
      wb_src_q   <= '0;
      fu_busy_q  <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      cnt        <= cnt_next;
      opnd_q     <= opnd_next;
      dst_q      <= dst_next;
      src_q      <= src_next;
      wb_valid_q <= wb_valid_next;
      wb_data_q  <= wb_data_next;
      wb_cout_q  <= wb_cout_next;
      wb_dst_q   <= wb_dst_next;
      wb_src_q   <= wb_src_next;
      fu_busy_q  <= fu_busy_next;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_cout  = wb_cout_q;
  assign bus.wb_dst   = wb_dst_q;
  assign bus.wb_src   = wb_src_q;
  assign bus.fu_busy  = fu_busy_q;

endmodule

// File: tb/tb_int_fu_scheduler.sv
// Self-checking bench for int_fu_scheduler: directed scenarios plus random
// traffic checked cycle by cycle against a transaction-level reference model.
module tb_int_fu_scheduler;
  import int_fu_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TAGW = 4;
  localparam int unsigned LAT  = 2;

  logic clk = 1'b0;
  logic rst;

  int_fu_scheduler_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

  int_fu_scheduler #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester-side stimulus state
  logic            pend  [NREQ];
  logic            op_r  [NREQ];
  logic [15:0]     a_r   [NREQ];
  logic [15:0]     b_r   [NREQ];
  logic [TAGW-1:0] dst_r [NREQ];
  logic            wbr;
  logic            rst_r;

  // Reference model: one outstanding operation, last granted index, result.
  logic            m_busy;
  int              m_last;
  int              m_gcyc;
  logic [15:0]     m_data;
  logic            m_cout;
  logic [TAGW-1:0] m_dst;
  int              m_src;
  int              cyc;
  int              nwb;
  int              hs_cyc;
  logic [15:0]     last_data;
  logic            last_cout;
  logic [TAGW-1:0] last_dst;
  logic [1:0]      last_src;
  int              gq[$];
  int              gcq[$];

  task automatic post(input int i, input logic op, input logic [15:0] a,
                      input logic [15:0] b, input logic [TAGW-1:0] dst);
    pend[i] = 1'b1; op_r[i] = op; a_r[i] = a; b_r[i] = b; dst_r[i] = dst;
  endtask

  function automatic logic any_pend();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NREQ; i++) r = r | pend[i];
    return r;
  endfunction

  // One clock cycle: drive at negedge, check #1 later, advance the model.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_wbv;
    int              win;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]           = pend[i];
      bus.req_op[i]              = op_r[i];
      bus.req_a[i*16 +: 16]      = a_r[i];
      bus.req_b[i*16 +: 16]      = b_r[i];
      bus.req_dst[i*TAGW +: TAGW] = dst_r[i];
    end
    bus.wb_ready = wbr;
    rst          = rst_r;
    #1;
    win = -1;
    if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_last + k) % NREQ;
        if (win < 0 && pend[j]) win = j;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    exp_wbv = m_busy && (cyc >= m_gcyc + int'(LAT) + 1);
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check_eq("fu_busy", 32'(bus.fu_busy), 32'(m_busy));
    check_eq("wb_valid", 32'(bus.wb_valid), 32'(exp_wbv));
    if (exp_wbv) begin
      check_eq("wb_data", 32'(bus.wb_data), 32'(m_data));
      check_eq("wb_cout", 32'(bus.wb_cout), 32'(m_cout));
      check_eq("wb_dst", 32'(bus.wb_dst), 32'(m_dst));
      check_eq("wb_src", 32'(bus.wb_src), 32'(m_src));
    end
    if (rst_r) begin
      m_busy = 1'b0;
      m_last = NREQ - 1;
    end else if (win >= 0) begin
      m_busy = 1'b1;
      m_gcyc = cyc;
      m_last = win;
      m_src  = win;
      m_dst  = dst_r[win];
      if (op_r[win] == OP_ADD) begin
        {m_cout, m_data} = 17'(a_r[win]) + 17'(b_r[win]);
      end else begin
        m_data = a_r[win] - b_r[win];
        m_cout = (a_r[win] < b_r[win]);
      end
      pend[win] = 1'b0;
      gq.push_back(win);
      gcq.push_back(cyc);
    end else if (exp_wbv && wbr) begin
      m_busy    = 1'b0;
      nwb++;
      hs_cyc    = cyc;
      last_data = bus.wb_data;
      last_cout = bus.wb_cout;
      last_dst  = bus.wb_dst;
      last_src  = bus.wb_src;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_wb(input int target);
    for (int k = 0; k < 80 && nwb < target; k++) step();
    check_eq("wb_count", 32'(nwb), 32'(target));
  endtask

  task automatic wait_grants(input int target);
    for (int k = 0; k < 80 && gq.size() < target; k++) step();
    check_eq("grant_count", 32'(gq.size()), 32'(target));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && (m_busy || any_pend()); k++) step();
    check_eq("drain", 32'({m_busy, any_pend()}), 32'd0);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int nwb_save;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; op_r[i] = 1'b0; a_r[i] = '0; b_r[i] = '0; dst_r[i] = '0;
    end
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_dst = '0; bus.wb_ready = 1'b1;
    wbr = 1'b1; rst_r = 1'b1; rst = 1'b1;
    m_busy = 1'b0; m_last = NREQ - 1; m_gcyc = 0; m_data = '0; m_cout = 1'b0;
    m_dst = '0; m_src = 0; cyc = 0; nwb = 0; hs_cyc = 0;
    last_data = '0; last_cout = 1'b0; last_dst = '0; last_src = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst_r = 1'b0;

    // Reset state
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check_eq("rst_wb_data", 32'(bus.wb_data), 32'd0);
    check_eq("rst_wb_cout", 32'(bus.wb_cout), 32'd0);
    check_eq("rst_wb_dst", 32'(bus.wb_dst), 32'd0);
    check_eq("rst_wb_src", 32'(bus.wb_src), 32'd0);
    check_eq("rst_fu_busy", 32'(bus.fu_busy), 32'd0);

    // Single SUB on requester 0
    post(0, OP_SUB, 16'd8, 16'd6, 4'd3);
    wait_wb(1);
    check_eq("t1_data", 32'(last_data), 32'd2);
    check_eq("t1_cout", 32'(last_cout), 32'd0);
    check_eq("t1_dst", 32'(last_dst), 32'd3);
    check_eq("t1_src", 32'(last_src), 32'd0);
    check_eq("t1_latency", 32'(hs_cyc - gcq[0]), 32'(LAT + 1));

    // Borrow and carry-out corner cases
    post(2, OP_SUB, 16'd6, 16'd8, 4'd5);
    wait_wb(2);
    check_eq("t2_sub_data", 32'(last_data), 32'hFFFE);
    check_eq("t2_sub_cout", 32'(last_cout), 32'd1);
    check_eq("t2_sub_src", 32'(last_src), 32'd2);
    post(1, OP_ADD, 16'hFFFF, 16'd1, 4'd7);
    wait_wb(3);
    check_eq("t2_add_data", 32'(last_data), 32'd0);
    check_eq("t2_add_cout", 32'(last_cout), 32'd1);

    // All four requesting out of reset
    wait_idle();
    for (int i = 0; i < NREQ; i++) post(i, 1'($urandom), pick16(), pick16(), 4'($urandom));
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    gq.delete(); gcq.delete();
    wait_wb(nwb + 4);
    check_eq("t3_ngrants", 32'(gq.size()), 32'd4);
    for (int i = 0; i < gq.size() && i < 4; i++) begin
      check_eq("t3_order", 32'(gq[i]), 32'(i));
      if (i > 0) check_eq("t3_spacing", 32'(gcq[i] - gcq[i-1]), 32'(LAT + 2));
    end

    // Rotation after a grant to requester 1
    wait_idle();
    post(1, OP_ADD, 16'd100, 16'd23, 4'd1);
    gq.delete(); gcq.delete();
    wait_grants(1);
    post(1, OP_SUB, 16'd5, 16'd9, 4'd2);
    post(3, OP_ADD, 16'd7, 16'd7, 4'd4);
    gq.delete(); gcq.delete();
    wait_grants(1);
    check_eq("t4_winner", 32'(gq[0]), 32'd3);

    // Writeback stall
    wait_idle();
    wbr = 1'b0;
    post(2, OP_ADD, 16'h1234, 16'h4321, 4'd9);
    for (int k = 0; k < 20 && !(m_busy && cyc >= m_gcyc + int'(LAT) + 1); k++) step();
    post(0, OP_SUB, 16'd1, 16'd2, 4'd6);
    repeat (5) step();
    check_eq("t5_hold_valid", 32'(bus.wb_valid), 32'd1);
    check_eq("t5_hold_data", 32'(bus.wb_data), 32'h5555);
    wbr = 1'b1;
    gq.delete(); gcq.delete();
    step();
    step();
    check_eq("t5_ngrants", 32'(gq.size()), 32'd1);
    check_eq("t5_winner", 32'(gq[0]), 32'd0);
    check_eq("t5_grant_cyc", 32'(gcq[0]), 32'(hs_cyc + 1));

    // Reset during execute
    wait_idle();
    post(2, OP_ADD, 16'd1, 16'd1, 4'd8);
    gq.delete(); gcq.delete();
    wait_grants(1);
    post(0, OP_ADD, 16'd3, 16'd4, 4'd10);
    post(3, OP_ADD, 16'd5, 16'd6, 4'd11);
    nwb_save = nwb;
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    check_eq("t6_fu_busy", 32'(bus.fu_busy), 32'd0);
    gq.delete(); gcq.delete();
    wait_grants(1);
    check_eq("t6_winner", 32'(gq[0]), 32'd0);
    check_eq("t6_no_wb", 32'(nwb), 32'(nwb_save));

    // Random traffic
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 39) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          post(i, 1'($urandom), pick16(), pick16(), 4'($urandom));
        end
      end
      wbr   = ($urandom_range(0, 3) != 0);
      rst_r = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_r = 1'b0;
    wbr   = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
